// File: rtl/shift_cmd_sequencer_pkg.sv
// Shared constants and state type for the shift-register command sequencer.
package shift_seq_pkg;

   localparam logic [1:0] MODE_HOLD    = 2'b00;
   localparam logic [1:0] MODE_INS_MSB = 2'b01;
   localparam logic [1:0] MODE_SHL     = 2'b10;
   localparam logic [1:0] MODE_LOAD    = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      DONE
   } state_t;

endpackage

// File: rtl/shift_cmd_sequencer_if.sv
// Command handshake bus: one "load data, shift N times" transaction per valid/ready.
interface shift_cmd_sequencer_if #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 3
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [WIDTH-1:0] cmd_data;
   logic [CNT_W-1:0] cmd_shift_cnt;
   logic             cmd_fill;
   logic             cmd_msb_mode;

   modport master (
      output cmd_valid, cmd_data, cmd_shift_cnt, cmd_fill, cmd_msb_mode,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_data, cmd_shift_cnt, cmd_fill, cmd_msb_mode,
      output cmd_ready
   );
endinterface

// File: rtl/shift_cmd_sequencer.sv
// Drives a universal shift register through LOAD, N shift cycles and HOLD per accepted command.
module shift_cmd_sequencer
   import shift_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   shift_cmd_sequencer_if.slave cmd,
   input  logic                 abort,
   output logic [1:0]           mode_o,
   output logic [WIDTH-1:0]     din_o,
   output logic                 in_o,
   output logic                 busy,
   output logic                 done
);

   // Counter must hold WIDTH itself, since counts are clamped to WIDTH.
   localparam int unsigned CLOG_W = $clog2(WIDTH + 1);
   localparam int unsigned CW     = (CNT_W > CLOG_W) ? CNT_W : CLOG_W;

   state_t           state_q, state_d;
   logic [CW-1:0]    rem_q, rem_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             fill_q, fill_d;
   logic             msb_q, msb_d;
   logic             ready_q;
   logic [1:0]       mode_d;
   logic             busy_d, done_d, ready_d;

   assign cmd.cmd_ready = ready_q;
   assign din_o         = data_q;
   assign in_o          = fill_q;

   // Next state, capture and output decode; outputs are registered from the next state.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      data_d  = data_q;
      fill_d  = fill_q;
      msb_d   = msb_q;
      mode_d  = MODE_HOLD;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      ready_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (cmd.cmd_valid) begin
               data_d  = cmd.cmd_data;
               fill_d  = cmd.cmd_fill;
               msb_d   = cmd.cmd_msb_mode;
               rem_d   = (CW'(cmd.cmd_shift_cnt) > CW'(WIDTH)) ? CW'(WIDTH)
                                                                : CW'(cmd.cmd_shift_cnt);
               state_d = LOAD;
            end
         end
         LOAD: begin
            if (abort)                  state_d = IDLE;
            else if (rem_q == CW'(0))   state_d = DONE;
            else                        state_d = SHIFT;
         end
         SHIFT: begin
            // Abort beats the final shift: no DONE once abort is seen.
            if (abort) begin
               state_d = IDLE;
            end else begin
               rem_d = rem_q - CW'(1);
               if (rem_q == CW'(1)) state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      unique case (state_d)
         LOAD: begin
            mode_d = MODE_LOAD;
            busy_d = 1'b1;
         end
         SHIFT: begin
            mode_d = msb_d ? MODE_INS_MSB : MODE_SHL;
            busy_d = 1'b1;
         end
         DONE:    done_d  = 1'b1;
         IDLE:    ready_d = 1'b1;
         default: ready_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rem_q   <= '0;
         data_q  <= '0;
         fill_q  <= 1'b0;
         msb_q   <= 1'b0;
         mode_o  <= MODE_HOLD;
         busy    <= 1'b0;
         done    <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         data_q  <= data_d;
         fill_q  <= fill_d;
         msb_q   <= msb_d;
         mode_o  <= mode_d;
         busy    <= busy_d;
         done    <= done_d;
         ready_q <= ready_d;
      end
   end

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Scoreboard bench: sequencer feeding a behavioural 4-bit universal shift register.
module tb_shift_cmd_sequencer;
   import shift_seq_pkg::*;

   localparam int unsigned WIDTH = 4;
   localparam int unsigned CNT_W = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             abort;
   logic [1:0]       mode_o;
   logic [WIDTH-1:0] din_o;
   logic             in_o, busy, done;

   shift_cmd_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) cmd_if ();

   shift_cmd_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk    (clk),
      .rst    (rst),
      .cmd    (cmd_if),
      .abort  (abort),
      .mode_o (mode_o),
      .din_o  (din_o),
      .in_o   (in_o),
      .busy   (busy),
      .done   (done)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit mon_en = 1'b0;

   // Downstream universal shift register (mode 01 replaces the MSB with in).
   logic [WIDTH-1:0] sreg;
   always @(posedge clk) begin
      cyc++;
      case (mode_o)
         2'b01:   sreg <= {in_o, sreg[WIDTH-2:0]};
         2'b10:   sreg <= {sreg[WIDTH-2:0], in_o};
         2'b11:   sreg <= din_o;
         default: sreg <= sreg;
      endcase
   end

   typedef struct {
      int               cyc;
      bit               is_done;
      logic [WIDTH-1:0] val;
   } sb_t;

   typedef struct {
      logic [1:0] mode;
      logic       busy;
      logic       ready;
   } cyc_exp_t;

   sb_t      sbq[$];
   cyc_exp_t exp_at[int];
   sb_t      mon_e;

   int prev_acc     = 0;
   int prev_n       = 0;
   bit prev_aborted = 1'b1;

   function automatic logic [WIDTH-1:0] ref_result(input logic [WIDTH-1:0] d, input int n,
                                                   input logic f, input logic m);
      logic [WIDTH-1:0] r;
      r = d;
      for (int i = 0; i < n; i++) r = m ? {f, r[WIDTH-2:0]} : {r[WIDTH-2:0], f};
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   // Monitor: per-cycle control expectations plus the done/abort scoreboard.
   always @(negedge clk) begin
      if (mon_en) begin
         if (exp_at.exists(cyc)) begin
            chk("mode", 32'(mode_o), 32'(exp_at[cyc].mode));
            chk("busy", 32'(busy), 32'(exp_at[cyc].busy));
            chk("ready", 32'(cmd_if.cmd_ready), 32'(exp_at[cyc].ready));
            exp_at.delete(cyc);
         end else begin
            chk("idle_mode", 32'(mode_o), 32'(MODE_HOLD));
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_ready", 32'(cmd_if.cmd_ready), 32'd1);
         end
         if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            total++;
            bad++;
            $display("FAIL sb_missed cyc=%0d expected_at=%0d", cyc, sbq[0].cyc);
            void'(sbq.pop_front());
         end
         if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
            mon_e = sbq.pop_front();
            if (mon_e.is_done) begin
               chk("done", 32'(done), 32'd1);
               chk("result", 32'(sreg), 32'(mon_e.val));
            end else begin
               chk("abort_no_done", 32'(done), 32'd0);
               chk("abort_held", 32'(sreg), 32'(mon_e.val));
            end
         end else begin
            chk("no_spurious_done", 32'(done), 32'd0);
         end
      end
   end

   task automatic send(input logic [WIDTH-1:0] d, input int cnt, input bit f, input bit m,
                       input int abort_k);
      int  n, acc, w, c;
      sb_t e;
      cmd_if.cmd_valid     = 1'b1;
      cmd_if.cmd_data      = d;
      cmd_if.cmd_shift_cnt = CNT_W'(cnt);
      cmd_if.cmd_fill      = f;
      cmd_if.cmd_msb_mode  = m;
      w = 0;
      while (cmd_if.cmd_ready !== 1'b1) begin
         @(negedge clk);
         w++;
         if (w > 40) begin
            total++;
            bad++;
            $display("FAIL accept_timeout cyc=%0d ready=%b", cyc, cmd_if.cmd_ready);
            cmd_if.cmd_valid = 1'b0;
            return;
         end
      end
      n   = (cnt > int'(WIDTH)) ? int'(WIDTH) : cnt;
      acc = cyc + 1;
      if (w > 0 && !prev_aborted) chk("cmd_period", 32'(acc - prev_acc), 32'(prev_n + 3));
      exp_at[acc] = '{MODE_LOAD, 1'b1, 1'b0};
      for (int k = 1; k <= n; k++) exp_at[acc + k] = '{(m ? MODE_INS_MSB : MODE_SHL), 1'b1, 1'b0};
      exp_at[acc + n + 1] = '{MODE_HOLD, 1'b0, 1'b0};
      exp_at[acc + n + 2] = '{MODE_HOLD, 1'b0, 1'b1};
      e.cyc = acc + n + 1;
      e.is_done = 1'b1;
      e.val = ref_result(d, n, f, m);
      sbq.push_back(e);
      @(negedge clk);
      cmd_if.cmd_valid = 1'b0;
      prev_acc     = acc;
      prev_n       = n;
      prev_aborted = (abort_k >= 0);
      if (abort_k >= 0) begin
         repeat (abort_k) @(negedge clk);
         abort = 1'b1;
         c = acc + abort_k;
         for (int j = c + 1; j <= acc + n + 2; j++) if (exp_at.exists(j)) exp_at.delete(j);
         exp_at[c + 1] = '{MODE_HOLD, 1'b0, 1'b1};
         void'(sbq.pop_back());
         e.cyc = c + 1;
         e.is_done = 1'b0;
         e.val = ref_result(d, abort_k, f, m);
         sbq.push_back(e);
         @(negedge clk);
         abort = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int w;
      w = 0;
      while (busy || done) begin
         @(negedge clk);
         w++;
         if (w > 40) begin
            total++;
            bad++;
            $display("FAIL idle_timeout cyc=%0d busy=%b done=%b", cyc, busy, done);
            return;
         end
      end
   endtask

   initial begin
      logic [WIDTH-1:0] d;
      int cnt, n, ak, c, w;
      bit f, m;

      rst = 1'b1;
      abort = 1'b0;
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_data = 4'hF;
      cmd_if.cmd_shift_cnt = 3'd1;
      cmd_if.cmd_fill = 1'b0;
      cmd_if.cmd_msb_mode = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_mode", 32'(mode_o), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
      chk("rst_din", 32'(din_o), 32'd0);
      chk("rst_in", 32'(in_o), 32'd0);
      rst = 1'b0;
      cmd_if.cmd_valid = 1'b0;
      @(negedge clk);
      mon_en = 1'b1;

      send(4'b1011, 2, 1'b0, 1'b0, -1);
      send(4'b0101, 0, 1'b0, 1'b0, -1);
      send(4'b0000, 7, 1'b1, 1'b0, -1);
      send(4'b1101, 3, 1'b0, 1'b0, 2);

      // Abort landing on the DONE cycle has no effect.
      send(4'b0110, 1, 1'b1, 1'b0, -1);
      w = 0;
      while (done !== 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;

      // Reset during SHIFT discards the command.
      wait_idle();
      send(4'b1010, 3, 1'b1, 1'b0, -1);
      @(negedge clk);
      rst = 1'b1;
      c = cyc;
      for (int j = c + 1; j <= c + 10; j++) if (exp_at.exists(j)) exp_at.delete(j);
      sbq.delete();
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_mode", 32'(mode_o), 32'd0);
      chk("midrst_din", 32'(din_o), 32'd0);
      chk("midrst_in", 32'(in_o), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_ready", 32'(cmd_if.cmd_ready), 32'd1);
      prev_aborted = 1'b1;
      send(4'b1001, 1, 1'b0, 1'b1, -1);

      for (int i = 0; i < 40; i++) begin
         d   = WIDTH'($urandom);
         cnt = $urandom_range(0, 7);
         f   = 1'($urandom);
         m   = 1'($urandom);
         n   = (cnt > int'(WIDTH)) ? int'(WIDTH) : cnt;
         ak  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n)) : -1;
         if ($urandom_range(0, 3) == 0) begin
            wait_idle();
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
         end else begin
            repeat ($urandom_range(0, 1)) @(negedge clk);
         end
         send(d, cnt, f, m, ak);
      end

      repeat (12) @(negedge clk);
      chk("sb_drained", 32'(sbq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/shift_cmd_sequencer.md
Name: shift_cmd_sequencer

Overview:
- Command-driven controller that sits directly upstream of the 4-bit universal shift register and drives its mode, din and in inputs.
- Accepts one command per valid/ready handshake, then emits a fixed sequence on the register's control lines: one parallel-load cycle, N shift cycles, then hold.
- Raises a one-cycle done pulse when the sequence completes.
- Purpose: callers issue "load X, shift N times" as one transaction instead of driving the mode lines cycle by cycle.

Parameters:
- WIDTH, 4, data width of the downstream shift register.
- CNT_W, 3, width of the shift-count field.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_data  input  WIDTH  word to parallel-load.
- cmd_shift_cnt  input  CNT_W  number of shift cycles after the load.
- cmd_fill  input  1  serial bit driven on in_o during shifts.
- cmd_msb_mode  input  1  1 selects mode 01 (MSB insert); 0 selects mode 10 (shift left, LSB insert).
- abort  input  1  cancels the in-flight sequence.
- mode_o  output  2  to shift register mode.
- din_o  output  WIDTH  to shift register din.
- in_o  output  1  to shift register in.
- busy  output  1  sequence in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE; mode_o=00; din_o=0; in_o=0; busy=0; done=0; cmd_ready=1 on the first cycle after reset. All capture registers clear to 0.
- Reset mid-sequence: same as reset. No done pulse. The captured command is discarded.
- Mode encodings: HOLD=00, INS_MSB=01, SHL=10, LOAD=11.
- Output decode: all outputs come only from registered state and capture registers. No combinational path from cmd_* or abort to any output.
- cmd_ready = (state==IDLE).
- Capture: on cmd_valid && cmd_ready at edge T, latch data, fill, msb_mode and the clamped count. The clamped count is min(cmd_shift_cnt, WIDTH). Go to LOAD.
- IDLE: mode_o=HOLD, busy=0.
- LOAD (exactly 1 cycle): mode_o=LOAD, din_o=captured data, busy=1.
  - Count 0: go to DONE.
  - Otherwise: remaining=count, go to SHIFT.
- SHIFT: mode_o = INS_MSB if msb_mode else SHL; in_o=fill; busy=1. Decrement remaining each cycle.
  - remaining==1: go to DONE.
  - Exactly `count` SHIFT cycles are emitted.
- DONE (1 cycle): mode_o=HOLD, done=1, busy=0, cmd_ready=0. Then go to IDLE.
- din_o and in_o keep their captured values outside LOAD/SHIFT. They are don't-care to the register while mode_o is HOLD.
- Abort in LOAD or SHIFT: next state IDLE, mode_o=HOLD from the next cycle, no done pulse.
  - Abort in the same cycle as the last shift: abort wins (no DONE).
  - Abort in IDLE or DONE: ignored.
- Back-to-back commands: the earliest next accept is the first IDLE cycle after DONE. Minimum command period = count + 3 cycles.
- Latency: handshake at edge T → LOAD during cycle T+1 → first shift in cycle T+2 → done high in cycle T+2+count.

Decomposition:
- Package shift_seq_pkg holds:
  - the MODE_HOLD, MODE_INS_MSB, MODE_SHL and MODE_LOAD constants (2-bit);
  - the state enum {IDLE, LOAD, SHIFT, DONE}.
- No sub-module. Counter and FSM stay in one module.
- Bench instantiates shift_cmd_sequencer feeding universal_shift_reg and checks the register's out.

Test Plan:
- rst held 2 cycles with cmd_valid=1 → mode_o=00, busy=0, done=0, cmd_ready=1. No LOAD issued while rst is high.
- cmd_data=1011, cnt=2, fill=0, msb_mode=0 → expected per cycle:
  - mode_o sequence 11,10,10,00.
  - Register out: 1011 → 0110 → 1100.
  - done high in the cycle after the second shift; cmd_ready back high in the following cycle.
- cmd_data=0101, cnt=0 → one LOAD cycle, then DONE. Register out=0101, done pulse 2 cycles after the handshake.
- cmd_shift_cnt=7 with WIDTH=4, fill=1, msb_mode=0, data=0000 → exactly 4 SHL cycles, final out=1111.
- cnt=3, abort asserted during the second SHIFT cycle → mode_o=00 on the next cycle, no done pulse, cmd_ready=1, register holds 2-shift value.
- rst asserted during SHIFT → next cycle IDLE with all outputs at reset values. A fresh command (data=1001, cnt=1, msb_mode=1, fill=0) then gives out 1001 → 0001.
